// File: rtl/ps2_key_event_filter.sv
// PS/2 scan-code byte stream -> discrete key events {brk, ext, code} with repeat suppression and noise drop.
// Latency: final byte of a sequence strobed in cycle N is at the FIFO head (evt_valid=1) in cycle N+1.
// Backpressure: evt_valid/evt_ready show-ahead FIFO; when full without a same-cycle pop the new event is dropped and ovf sets.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   byte_valid/data    one-cycle strobe + scan-code byte from the PS/2 receiver
//   evt_valid/ready    FIFO not empty / consumer pops the head
//   evt_data           {brk, ext, code[7:0]} at the FIFO head
//   evt_level          FIFO occupancy, 0..FIFO_DEPTH
//   ovf, seq_err       sticky error flags (event dropped / sequence timed out), cleared by err_clr
module ps2_key_event_filter #(
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_SUPPRESS = 1,
    parameter int TIMEOUT_CYC     = 1_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [9:0]                    evt_data,
    output logic [$clog2(FIFO_DEPTH):0]   evt_level,
    output logic                          ovf,
    output logic                          seq_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      skip_q, skip_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            timeout_fire;

    logic            raw_vld, raw_brk, raw_ext, raw_pause;
    logic [7:0]      raw_code;
    logic            held_vld_q, held_ext_q;
    logic [7:0]      held_code_q;
    logic            held_match, emit;

    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            push, pop, full;
    logic            ovf_q, seq_err_q;

    function automatic logic is_noise(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Expires on the TIMEOUT_CYC-th consecutive idle cycle inside a sequence; a byte in that cycle wins.
    assign timeout_fire = (TIMEOUT_CYC != 0) && (state_q != S_IDLE) && !byte_valid && (to_cnt_q == TO_LAST);

    // ---------------- parser FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            skip_q   <= 3'd0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // ---------------- parser FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        to_cnt_d = to_cnt_q + TW'(1);
        if (byte_valid || state_q == S_IDLE || timeout_fire) begin
            to_cnt_d = '0;
        end
        if (byte_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_data == 8'hE1) begin
                        // Pause: 7 more bytes follow the E1 prefix
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end
                end
                S_EXT:     state_d = (byte_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_BRK:     state_d = S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end else if (timeout_fire) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- parser FSM: outputs (raw event) ----------------
    always_comb begin
        raw_vld   = 1'b0;
        raw_brk   = 1'b0;
        raw_ext   = 1'b0;
        raw_pause = 1'b0;
        raw_code  = byte_data;
        if (byte_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_data == 8'hE1) begin
                        raw_vld   = 1'b1;
                        raw_ext   = 1'b1;
                        raw_pause = 1'b1;
                    end else if (byte_data != 8'hE0 && byte_data != 8'hF0 && !is_noise(byte_data)) begin
                        raw_vld = 1'b1;
                    end
                end
                S_EXT: begin
                    // E0 12 is the keyboard's fake-shift and carries no key information
                    if (byte_data != 8'hF0 && byte_data != 8'h12) begin
                        raw_vld = 1'b1;
                        raw_ext = 1'b1;
                    end
                end
                S_BRK: begin
                    raw_vld = 1'b1;
                    raw_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    if (byte_data != 8'h12) begin
                        raw_vld = 1'b1;
                        raw_brk = 1'b1;
                        raw_ext = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- typematic repeat filter ----------------
    assign held_match = held_vld_q && (held_ext_q == raw_ext) && (held_code_q == raw_code);
    assign emit = raw_vld && (raw_pause || raw_brk || !((REPEAT_SUPPRESS != 0) && held_match));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_vld_q  <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= 8'h00;
        end else if (raw_vld && !raw_pause) begin
            if (!raw_brk && emit) begin
                held_vld_q  <= 1'b1;
                held_ext_q  <= raw_ext;
                held_code_q <= raw_code;
            end else if (raw_brk && held_match) begin
                held_vld_q  <= 1'b0;
            end
        end
    end

    // ---------------- show-ahead event FIFO ----------------
    assign full  = (level_q == LVL_FULL);
    assign pop   = evt_valid && evt_ready;
    assign push  = emit && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {raw_brk, raw_ext, raw_code};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            ovf_q     <= (emit && full && !pop) || (ovf_q && !err_clr);
            seq_err_q <= timeout_fire || (seq_err_q && !err_clr);
        end
    end

    assign evt_valid = (level_q != '0);
    assign evt_data  = mem_q[rd_ptr_q];
    assign evt_level = level_q;
    assign ovf       = ovf_q;
    assign seq_err   = seq_err_q;

endmodule
